// File: rtl/ldl_fifo_ws_v1.sv
// ldl_fifo_ws_v1: write-side controller for the single-clock FIFO.
// Owns the write pointer, drives the RAM write port, and produces registered
// full/almost-full flags, the occupancy/free-space counts and a sticky overflow flag.
// Optional build macro LDL_FIFO_WS_OVF_CNT_EN adds a saturating overflow-attempt
// counter on ovf_cnt; without it ovf_cnt is tied to zero.
module ldl_fifo_ws_v1 #(
    parameter int unsigned AW       = 8,
    parameter int unsigned AF_LEVEL = 2**AW - 2,
    parameter int unsigned OVF_CW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    output logic              full,
    output logic              almost_full,
    output logic              mw,
    output logic [AW-1:0]     wa,
    output logic [AW:0]       w_pt,
    input  logic [AW:0]       r_pt,
    output logic [AW:0]       wcnt,
    output logic [AW:0]       free,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [OVF_CW-1:0] ovf_cnt
);

    localparam logic [AW:0]   Depth   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   DepthM1 = Depth - 1'b1;
    localparam logic [AW+1:0] AfLevel = (AW+2)'(AF_LEVEL);

    logic [AW:0]   w_pt_d, w_pt_q;
    logic          full_d, full_q;
    logic          af_d, af_q;
    logic          ovf_d, ovf_q;
    logic          fw;
    logic          ovf_hit;
    logic [AW:0]   wcnt_w;
    logic [AW+1:0] af_sum;

    // Accepted write, overflow attempt and pointer-derived counts.
    always_comb begin
        fw      = we & ~full_q;
        ovf_hit = we & full_q;
        // Modular subtraction stays correct across the lap-bit wrap.
        wcnt_w  = w_pt_q - r_pt;
        // One bit wider so occupancy plus the pending write cannot overflow.
        af_sum  = {1'b0, wcnt_w} + {{(AW+1){1'b0}}, fw};
    end

    // Next-state for pointer, flags and sticky overflow.
    always_comb begin
        w_pt_d = w_pt_q;
        full_d = 1'b0;
        af_d   = 1'b0;
        ovf_d  = ovf_q;
        if (fw) begin
            w_pt_d = w_pt_q + 1'b1;
        end
        // Reads in this cycle are not looked ahead; flags may over-report by one cycle.
        if (wcnt_w == Depth) begin
            full_d = 1'b1;
        end else if ((wcnt_w == DepthM1) && fw) begin
            full_d = 1'b1;
        end
        af_d = (af_sum >= AfLevel);
        // Set has priority over clear.
        if (ovf_hit) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_pt_q <= '0;
            full_q <= 1'b0;
            af_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            w_pt_q <= w_pt_d;
            full_q <= full_d;
            af_q   <= af_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef LDL_FIFO_WS_OVF_CNT_EN
    localparam logic [OVF_CW-1:0] OvfMax = '1;

    logic [OVF_CW-1:0] ovf_cnt_d, ovf_cnt_q;

    // Saturating overflow-attempt counter; a same-cycle attempt and clear leaves 1.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_hit) begin
            if (ovf_clr) begin
                ovf_cnt_d = OVF_CW'(1);
            end else if (ovf_cnt_q != OvfMax) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
        end else if (ovf_clr) begin
            ovf_cnt_d = '0;
        end
    end

    // Overflow counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = '0;
`endif

    assign mw          = fw;
    assign wa          = w_pt_q[AW-1:0];
    assign w_pt        = w_pt_q;
    assign wcnt        = wcnt_w;
    assign free        = Depth - wcnt_w;
    assign full        = full_q;
    assign almost_full = af_q;
    assign ovf         = ovf_q;

endmodule
